// File: rtl/rtc_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// rtc_pkg : RTC register map, address table and sequencer states
// Revision 1.0
// ------------------------------------------------------------------
package rtc_pkg;

  localparam logic [2:0] IDX_CMD  = 3'd0;
  localparam logic [2:0] IDX_SEG  = 3'd1;
  localparam logic [2:0] IDX_MIN  = 3'd2;
  localparam logic [2:0] IDX_HORA = 3'd3;
  localparam logic [2:0] IDX_DIA  = 3'd4;
  localparam logic [2:0] IDX_MES  = 3'd5;
  localparam logic [2:0] IDX_ANIO = 3'd6;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_CYCLE = 3'd1,
    SEQ_STORE = 3'd2,
    SEQ_GAP_S = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    CYC_IDLE  = 2'd0,
    CYC_ADDR  = 2'd1,
    CYC_GAP_A = 2'd2,
    CYC_DATA  = 2'd3
  } cyc_state_t;

  // RTC bus address for each RAM index
  function automatic logic [7:0] addr_of(input logic [2:0] idx);
    case (idx)
      IDX_CMD:  addr_of = 8'hF0;
      IDX_SEG:  addr_of = 8'h21;
      IDX_MIN:  addr_of = 8'h22;
      IDX_HORA: addr_of = 8'h23;
      IDX_DIA:  addr_of = 8'h24;
      IDX_MES:  addr_of = 8'h25;
      IDX_ANIO: addr_of = 8'h26;
      default:  addr_of = 8'h00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_rd_cycle.sv
`default_nettype none
// ------------------------------------------------------------------
// rtc_rd_cycle : one multiplexed ADDR -> GAP -> DATA read cycle
// Revision 1.0
// ------------------------------------------------------------------
module rtc_rd_cycle
  import rtc_pkg::*;
#(
  parameter int T_ADDR = 8,
  parameter int T_DATA = 8,
  parameter int T_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] addr,
  input  logic [7:0] ad_bus_in,
  output logic [7:0] ad_bus_out,
  output logic       ad_bus_oe,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] data,
  output logic       ready
);

  cyc_state_t state, next_state;
  logic [7:0] cnt, next_cnt;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      CYC_IDLE: if (go) begin
        next_state = CYC_ADDR;
        next_cnt   = 8'(T_ADDR - 1);
      end
      CYC_ADDR: if (cnt == 8'd0) begin
        next_state = CYC_GAP_A;
        next_cnt   = 8'(T_GAP - 1);
      end else next_cnt = cnt - 8'd1;
      CYC_GAP_A: if (cnt == 8'd0) begin
        next_state = CYC_DATA;
        next_cnt   = 8'(T_DATA - 1);
      end else next_cnt = cnt - 8'd1;
      CYC_DATA: if (cnt == 8'd0) next_state = CYC_IDLE;
                else next_cnt = cnt - 8'd1;
      default: next_state = CYC_IDLE;
    endcase
  end

  // High during the final DATA cycle; the byte is taken on the edge that ends it
  assign ready = (state == CYC_DATA) && (cnt == 8'd0);

  // Strobes are decoded from next_state so every pin comes straight off a flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CYC_IDLE;
      cnt        <= 8'd0;
      cs         <= 1'b1;
      rd         <= 1'b1;
      wr         <= 1'b1;
      a_d        <= 1'b1;
      ad_bus_oe  <= 1'b0;
      ad_bus_out <= 8'h00;
      data       <= 8'h00;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      cs        <= !((next_state == CYC_ADDR) || (next_state == CYC_DATA));
      wr        <= (next_state != CYC_ADDR);
      rd        <= (next_state != CYC_DATA);
      a_d       <= (next_state != CYC_ADDR);
      ad_bus_oe <= (next_state == CYC_ADDR);
      if ((state == CYC_IDLE) && go) ad_bus_out <= addr;
      else if (next_state != CYC_ADDR) ad_bus_out <= 8'h00;
      if (ready) data <= ad_bus_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rtc_read_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// rtc_read_seq : reads the seven RTC registers into the time RAM
// Revision 1.0
// ------------------------------------------------------------------
module rtc_read_seq
  import rtc_pkg::*;
#(
  parameter int T_ADDR = 8,
  parameter int T_DATA = 8,
  parameter int T_GAP  = 4,
  parameter int N_REG  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       do_it_leer,
  input  logic [7:0] ad_bus_in,
  output logic [7:0] ad_bus_out,
  output logic       ad_bus_oe,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [2:0] ram_waddr,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  output logic       busy,
  output logic       done
);

  seq_state_t state, next_state;
  logic [2:0] idx, next_idx, go_idx;
  logic [7:0] cnt, next_cnt;
  logic       cyc_go, cyc_ready;

  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_cnt   = cnt;
    cyc_go     = 1'b0;
    go_idx     = idx;
    case (state)
      SEQ_IDLE: if (do_it_leer) begin
        next_state = SEQ_CYCLE;
        next_idx   = 3'd0;
        go_idx     = 3'd0;
        cyc_go     = 1'b1;
      end
      SEQ_CYCLE: if (cyc_ready) next_state = SEQ_STORE;
      SEQ_STORE: begin
        next_state = SEQ_GAP_S;
        next_cnt   = 8'(T_GAP - 1);
      end
      SEQ_GAP_S: if (cnt != 8'd0) next_cnt = cnt - 8'd1;
                 else if (idx == 3'(N_REG - 1)) next_state = SEQ_DONE;
                 else begin
                   next_state = SEQ_CYCLE;
                   next_idx   = idx + 3'd1;
                   go_idx     = idx + 3'd1;
                   cyc_go     = 1'b1;
                 end
      SEQ_DONE: next_state = SEQ_IDLE;
      default:  next_state = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEQ_IDLE;
      idx       <= 3'd0;
      cnt       <= 8'd0;
      ram_we    <= 1'b0;
      ram_waddr <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= next_state;
      idx    <= next_idx;
      cnt    <= next_cnt;
      ram_we <= (next_state == SEQ_STORE);
      if (next_state == SEQ_STORE) ram_waddr <= idx;
      busy   <= (next_state != SEQ_IDLE);
      done   <= (next_state == SEQ_DONE);
    end
  end

  rtc_rd_cycle #(
    .T_ADDR(T_ADDR),
    .T_DATA(T_DATA),
    .T_GAP (T_GAP)
  ) u_cycle (
    .clk       (clk),
    .reset     (reset),
    .go        (cyc_go),
    .addr      (addr_of(go_idx)),
    .ad_bus_in (ad_bus_in),
    .ad_bus_out(ad_bus_out),
    .ad_bus_oe (ad_bus_oe),
    .a_d       (a_d),
    .cs        (cs),
    .rd        (rd),
    .wr        (wr),
    .data      (ram_wdata),
    .ready     (cyc_ready)
  );

endmodule
`default_nettype wire

// File: tb/tb_rtc_read_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_rtc_read_seq : scoreboard bench with an RTC bus model
// Revision 1.0
// ------------------------------------------------------------------
module tb_rtc_read_seq;

  localparam int T_ADDR = 8;
  localparam int T_DATA = 8;
  localparam int T_GAP  = 4;
  localparam int PER    = T_ADDR + T_GAP + T_DATA + 1 + T_GAP;
  localparam int DONE_N = 7 * PER + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       do_it_leer;
  logic [7:0] ad_bus_in = 8'h00;
  logic [7:0] ad_bus_out;
  logic       ad_bus_oe, a_d, cs, rd, wr, ram_we, busy, done;
  logic [2:0] ram_waddr;
  logic [7:0] ram_wdata;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tab[7] = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
  logic [7:0] rtc_mem[256];
  logic [7:0] lat_addr = 8'h00;
  int         dcnt = 0;
  bit         noise_fixed;
  int         cyc = 0;
  int         seq_start;
  int         total = 0;
  int         bad = 0;

  rtc_read_seq #(.T_ADDR(T_ADDR), .T_DATA(T_DATA), .T_GAP(T_GAP), .N_REG(7)) dut (
    .clk(clk), .reset(reset), .do_it_leer(do_it_leer), .ad_bus_in(ad_bus_in),
    .ad_bus_out(ad_bus_out), .ad_bus_oe(ad_bus_oe), .a_d(a_d), .cs(cs), .rd(rd),
    .wr(wr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Position inside the running sequence: 1 = first ADDR cycle, DONE_N = DONE cycle
  function automatic int cur_n();
    return (seq_start < 0) ? 0 : cyc - seq_start + 1;
  endfunction

  function automatic bit model_active();
    int n;
    n = cur_n();
    return (n >= 1) && (n <= DONE_N);
  endfunction

  // RTC chip model: latches the address, answers only on the last DATA cycle
  always @(negedge clk) begin
    if (!cs && !wr && ad_bus_oe) lat_addr = ad_bus_out;
    if (!cs && !rd) begin
      dcnt++;
      if (dcnt == T_DATA) ad_bus_in = rtc_mem[lat_addr];
      else ad_bus_in = noise_fixed ? 8'hAA : ~rtc_mem[lat_addr];
    end else begin
      dcnt = 0;
      ad_bus_in = 8'h00;
    end
  end

  always @(negedge clk) begin : mon
    int n, r, p;
    logic [6:0] ctl, want;
    wr_t e;
    ctl = {cs, rd, wr, ad_bus_oe, ram_we, busy, done};
    if (!reset) begin
      chk("reset_ctl", 32'(ctl), 32'(7'b1110000));
      chk("reset_data", 32'({a_d, ad_bus_out, ram_waddr, ram_wdata}), 32'({1'b1, 19'd0}));
    end else begin
      n = cur_n();
      want = 7'b1110000;
      if (n >= 1 && n <= DONE_N) begin
        if (n == DONE_N) want = 7'b1110011;
        else begin
          r = (n - 1) / PER;
          p = (n - 1) % PER;
          if (p < T_ADDR) begin
            want = 7'b0101010;
            chk("addr_phase", 32'({a_d, ad_bus_out}), 32'({1'b0, tab[r]}));
          end else if (p < T_ADDR + T_GAP) want = 7'b1110010;
          else if (p < T_ADDR + T_GAP + T_DATA) begin
            want = 7'b0010010;
            chk("data_a_d", 32'(a_d), 32'd1);
          end else if (p == T_ADDR + T_GAP + T_DATA) want = 7'b1110110;
          else want = 7'b1110010;
        end
      end
      chk("ctl", 32'(ctl), 32'(want));
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_we: got idx %0d data %0h want no write at cycle %0d",
                   ram_waddr, ram_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_idx", 32'(ram_waddr), 32'(e.idx));
          chk("wr_data", 32'(ram_wdata), 32'(e.data));
        end
      end
    end
  end

  task automatic start_pulse();
    @(negedge clk);
    if (!model_active()) begin
      seq_start = cyc + 1;
      for (int i = 0; i < 7; i++) exp_q.push_back('{idx: 3'(i), data: rtc_mem[tab[i]]});
    end
    do_it_leer = 1'b1;
    @(negedge clk);
    do_it_leer = 1'b0;
  endtask

  task automatic goto_n(input int k);
    int g;
    g = 0;
    while (cur_n() < k && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) begin
      total++;
      bad++;
      $display("FAIL goto_timeout: got n=%0d want n=%0d", cur_n(), k);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (model_active() && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got still busy want idle");
    end
  endtask

  task automatic rand_mem();
    for (int a = 0; a < 256; a++) rtc_mem[a] = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    do_it_leer = 1'b0;
    noise_fixed = 1'b1;
    seq_start = -1;
    rand_mem();
    rtc_mem[8'hF0] = 8'h10; rtc_mem[8'h21] = 8'h59; rtc_mem[8'h22] = 8'h45;
    rtc_mem[8'h23] = 8'h23; rtc_mem[8'h24] = 8'h31; rtc_mem[8'h25] = 8'h12;
    rtc_mem[8'h26] = 8'h16;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);

    // Full read with the reference byte set
    start_pulse();
    wait_idle();

    // Capture edge plus ignored starts while busy and in the DONE cycle
    rand_mem();
    rtc_mem[8'h21] = 8'h55;
    start_pulse();
    goto_n(59);
    start_pulse();
    goto_n(DONE_N - 1);
    start_pulse();
    wait_idle();

    // Asynchronous reset during DATA of idx 3, then a clean restart
    noise_fixed = 1'b0;
    rand_mem();
    start_pulse();
    goto_n(3 * PER + T_ADDR + T_GAP + 3);
    #2 reset = 1'b0;
    seq_start = -1;
    exp_q.delete();
    #1 chk("async_rst", 32'({cs, rd, wr, ad_bus_oe, ram_we}), 32'(5'b11100));
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    start_pulse();
    wait_idle();

    // Random contents, random idle gaps, a random ignored start
    for (int run = 0; run < 3; run++) begin
      int k;
      rand_mem();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start_pulse();
      k = $urandom_range(2, DONE_N);
      goto_n(k - 1);
      start_pulse();
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
